// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment table, blanking constants and scan state encoding.
package seg7_pkg;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  // Active-low {G..A}; listed from F down to 0 so SEG_TABLE[n] is digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[hex_i];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit multiplexed 7-segment scanner with blanking gap and frame tick.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [3:0] wr_data_i,
  input  logic       wr_dp_i,
  input  logic [7:0] digit_en_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [7:0] an_o,
  output logic       frame_tick_o
);
  logic [7:0][3:0] val_q;
  logic [7:0]      dpb_q;
  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [6:0]      seg_q, seg_d, dec_seg;
  logic [7:0]      an_q, an_d;
  logic            dp_q, dp_d, tick_q, tick_d, lit;

  seg7_hex_decode u_dec (.hex_i(val_q[idx_q]), .seg_o(dec_seg));

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      val_q <= '0;
      dpb_q <= '0;
    end else if (wr_en_i) begin
      val_q[wr_addr_i] <= wr_data_i;
      dpb_q[wr_addr_i] <= wr_dp_i;
    end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 32'd1;
    tick_d  = 1'b0;
    if (state_q == BLANK) begin
      if (cnt_q == BLANK_CYC - 1) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    end else if (cnt_q == SCAN_DIV - BLANK_CYC - 1) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx_q + 3'd1;
      tick_d  = idx_q == 3'd7;
    end
    // A disabled digit still burns its slot so the frame period never changes.
    lit  = state_q == SHOW && digit_en_i[idx_q];
    an_d = lit ? ~(8'd1 << idx_q) : AN_OFF;
    seg_d = lit ? dec_seg : SEG_BLANK;
    dp_d = lit ? ~dpb_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end

  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_tick_o = tick_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed + random stimulus against a slot-arithmetic display model.
module tb_seg7_scan_ctrl;
  localparam int SD = 10, BC = 2, FR = 8 * SD;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, wr_dp = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [7:0] de = 8'hFF;
  logic [6:0] seg;
  logic [7:0] an;
  logic dp, ft;
  int errs = 0, checks = 0, k = 0, last_tick = -1;
  logic [6:0] dec [16];
  logic [3:0] mv [8];
  logic md [8];

  seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .wr_dp_i(wr_dp), .digit_en_i(de),
    .seg_o(seg), .dp_o(dp), .an_o(an), .frame_tick_o(ft));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin mv[i] = '0; md[i] = 1'b0; end
  endtask

  // Position in the frame after k edges determines what the next edge shows.
  task automatic tick();
    int p, i;
    logic sh, w, wd;
    logic [2:0] a;
    logic [3:0] d;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    p = k % FR;
    i = p / SD;
    sh = (p % SD) >= BC && de[i];
    e_an = sh ? ~(8'd1 << i) : 8'hFF;
    e_seg = sh ? dec[mv[i]] : 7'h7F;
    e_dp = sh ? ~md[i] : 1'b1;
    e_ft = ((k + 1) % FR) == 0;
    w = wr_en; a = wr_addr; d = wr_data; wd = wr_dp;
    @(posedge clk);
    k++;
    if (w) begin mv[a] = d; md[a] = wd; end
    #1;
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, e_dp);
    chk("frame_tick", ft, e_ft);
    if (ft === 1'b1) begin
      if (last_tick >= 0) chk("frame_period", k - last_tick, FR);
      last_tick = k;
    end
  endtask

  task automatic rand_write();
    wr_en = ($urandom % 4) == 0;
    wr_addr = 3'($urandom);
    wr_data = 4'($urandom);
    wr_dp = 1'($urandom);
  endtask

  initial begin
    logic [3:0] vals [8];
    bit seen_fd;
    dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vals = '{4'd1, 4'd9, 4'd7, 4'd6, 4'd0, 4'd3, 4'd1, 4'd9};
    clear_model();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_ft", ft, 1'b0);
    rst_n = 1'b1;
    k = 0;
    repeat (3) tick();
    chk("first_an", an, 8'hFE);
    // Load 1,9,7,6,0,3,1,9 back-to-back.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = vals[i]; wr_dp = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    seen_fd = 0;
    while (k < 2 * FR) begin
      tick();
      if (an === 8'hFD && !seen_fd) begin
        chk("seg_digit1", seg, 7'b0010000);
        seen_fd = 1;
      end
    end
    // Free-run three frames with random writes.
    repeat (3 * FR) begin rand_write(); tick(); end
    wr_en = 1'b0;
    de = 8'h0F;
    repeat (2 * FR) begin rand_write(); tick(); end
    wr_en = 1'b0;
    de = 8'hFF;
    // Mid-SHOW write to the digit being shown.
    while (k % FR != 2 * SD + BC + 3) tick();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hE; wr_dp = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    chk("midshow_seg", seg, 7'b0000110);
    chk("midshow_dp", dp, 1'b0);
    chk("midshow_an", an, 8'hFB);
    repeat (FR) tick();
    // Asynchronous reset in the middle of digit 5's SHOW.
    while (k % FR != 5 * SD + BC + 4) begin rand_write(); tick(); end
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", an, 8'hFF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);
    chk("async_ft", ft, 1'b0);
    clear_model();
    last_tick = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0;
    repeat (3) tick();
    chk("post_rst_an", an, 8'hFE);
    chk("post_rst_seg", seg, 7'b1000000);
    repeat (2 * FR) begin
      rand_write();
      if ($urandom % 16 == 0) de = 8'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-division scan controller for the board's 8-digit common-anode 7-segment display.
- Holds one 4-bit hex value plus a decimal point per digit. Upstream logic (counters, code converters) writes these through a simple write port.
- Shares the single segment bus among the 8 digits in a fixed round-robin order, inserting a blanking gap between digits to prevent ghosting.
- Emits a frame tick after every full 8-digit pass; upstream sequencers use it as their pacing strobe.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot, blank plus show (1 kHz slot rate at 100 MHz). Legal range: SCAN_DIV > BLANK_CYC.
- BLANK_CYC, 1000: clk cycles at the start of each slot with all anodes off. Legal range: BLANK_CYC ≥ 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low. One clock domain only.
- wr_en  in  1  write strobe for the digit store.
- wr_addr  in  3  digit index to write, 0 = rightmost (AN0).
- wr_data  in  4  hex value to store, 0..F.
- wr_dp  in  1  decimal point for the addressed digit, 1 = lit.
- digit_en  in  8  per-digit enable; bit i gates AN(i).
- seg  out  7  segment drive {G,F,E,D,C,B,A}, active-low.
- dp  out  1  decimal-point drive, active-low.
- an  out  8  anode drive {AN7..AN0}, active-low.
- frame_tick  out  1  one-cycle pulse at the end of each 8-slot frame.

Behaviour:
- Reset (rst=0, takes effect immediately, independent of clk):
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
  - All digit values and dp bits cleared to 0.
  - FSM goes to BLANK with idx=0 and slot counter at 0.
- FSM states: BLANK and SHOW.
  - BLANK holds for BLANK_CYC cycles, then moves to SHOW.
  - SHOW holds for SCAN_DIV−BLANK_CYC cycles, then moves to BLANK with idx=idx+1 (mod 8).
  - Slot counter is 32 bits and resets at every state change.
- Outputs are registered. The an/seg/dp value at edge n+1 is a function of state, idx and the digit store as they stand after edge n.
  - BLANK: an=FF, seg=7F, dp=1.
  - SHOW, digit_en[idx]=1: an has only bit idx low; seg=decode(value[idx]); dp=~dp_bit[idx].
  - SHOW, digit_en[idx]=0: an=FF and seg=7F, but the slot still consumes its full time. Frame period is constant at 8×SCAN_DIV cycles.
- frame_tick is high for exactly one cycle, coincident with the SHOW→BLANK transition out of idx 7 (wrap to 0).
- Writes:
  - wr_en sampled at edge t updates value/dp of wr_addr at edge t. Outputs reflect it at edge t+1.
  - Writing the digit currently shown changes seg/dp mid-slot; an is unaffected and the scan timing does not change.
  - Back-to-back writes are allowed, one per cycle; the last write wins.
- digit_en is sampled every cycle. A change mid-SHOW takes effect at the next edge.
- decode (active-low, {G..A}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset asserted mid-slot: outputs blank immediately. After release, scanning restarts at idx 0 in BLANK with a full BLANK_CYC gap.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry active-low segment constant table;
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF;
  - the state encoding constants (BLANK=0, SHOW=1).
- Sub-module seg7_hex_decode (4-bit in, 7-bit out, purely combinational, table-driven from seg7_pkg). It is also reused by other display blocks.

Test Plan (sim params SCAN_DIV=10, BLANK_CYC=2):
1. Hold rst=0 for 5 cycles, release → an=FF, seg=7F, dp=1, frame_tick=0; first an=FE appears 3 cycles after the first active edge.
2. Write 1,9,7,6,0,3,1,9 to addr 0..7, digit_en=FF → an cycles FE,FD,FB,…,7F, each low for 8 cycles after 2 blank cycles; during an=FD, seg=0010000.
3. Free-run 3 frames → frame_tick pulses exactly once per 80 cycles, at the idx7→0 transition, each pulse 1 cycle wide.
4. digit_en=8'h0F → an[7:4] never low; slots 4..7 output an=FF/seg=7F for 10 cycles each; frame period still 80.
5. Mid-SHOW of idx 2, write addr 2 = 4'hE with wr_dp=1 → one cycle later seg=0000110 and dp=0; an stays FB; slot ends on schedule.
6. Assert rst during SHOW of idx 5 → an=FF, seg=7F without waiting for clk; after release, the store reads all zeros and the scan restarts at idx 0 with 2 blank cycles.
